// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader: state encodings, width defaults
// and the layout of the two-byte length header.
package prog_loader_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_LEN_HI  = 3'd1;
  localparam logic [STATE_W-1:0] S_LEN_LO  = 3'd2;
  localparam logic [STATE_W-1:0] S_BYTE_HI = 3'd3;
  localparam logic [STATE_W-1:0] S_BYTE_LO = 3'd4;
  localparam logic [STATE_W-1:0] S_WRITE   = 3'd5;
  localparam logic [STATE_W-1:0] S_RUN     = 3'd6;
  localparam logic [STATE_W-1:0] S_ERR     = 3'd7;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 16;

  // Header is {LEN_HI, LEN_LO}; only bit 0 of LEN_HI carries data (count[8]).
  localparam int         LEN_W            = 9;
  localparam int         LEN_MSB_BIT      = 0;
  localparam logic [7:0] LEN_HI_RSVD_MASK = 8'hFE;

  function automatic logic len_hi_ok(input logic [7:0] b);
    return (b & LEN_HI_RSVD_MASK) == 8'h00;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses a length header, assembles 16-bit words,
// writes them to code memory at consecutive addresses, then enables the datapath.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              code_w_en,
  output logic [ADDR_W-1:0] code_addr,
  output logic [DATA_W-1:0] code_data,
  output logic              run,
  output logic              busy,
  output logic              error
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nx;
  logic [LEN_W-1:0]   count;
  logic [ADDR_W-1:0]  addr;
  logic [7:0]         hi_byte;
  logic               accept;
  logic               last_word;
  logic               can_start;

  assign accept    = rx_valid && rx_ready;
  assign last_word = (addr == ADDR_W'(count - LEN_W'(1)));
  assign can_start = (state == S_IDLE) || (state == S_RUN) || (state == S_ERR);

  // All outputs except the write port decode directly from state, so reset
  // forces them low without waiting for a clock.
  assign rx_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_BYTE_HI) || (state == S_BYTE_LO);
  assign busy      = rx_ready || (state == S_WRITE);
  assign code_w_en = (state == S_WRITE);
  assign run       = (state == S_RUN);
  assign error     = (state == S_ERR);

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_RUN, S_ERR: begin
          if (start) state_nx = S_LEN_HI;
        end
        S_LEN_HI: begin
          if (accept) state_nx = len_hi_ok(rx_data) ? S_LEN_LO : S_ERR;
        end
        S_LEN_LO: begin
          if (accept) state_nx = ({count[LEN_W-1], rx_data} == '0) ? S_ERR : S_BYTE_HI;
        end
        S_BYTE_HI: begin
          if (accept) state_nx = S_BYTE_LO;
        end
        S_BYTE_LO: begin
          if (accept) state_nx = S_WRITE;
        end
        S_WRITE: begin
          state_nx = last_word ? S_RUN : S_BYTE_HI;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The high byte is staged privately and the write port is updated as a
  // whole word on entry to WRITE, so code_addr/code_data never change mid-word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      addr      <= '0;
      hi_byte   <= '0;
      code_addr <= '0;
      code_data <= '0;
    end else if (!abort) begin
      if (can_start && start) begin
        addr <= '0;
      end
      if (accept) begin
        case (state)
          S_LEN_HI:  count[LEN_W-1] <= rx_data[LEN_MSB_BIT];
          S_LEN_LO:  count[7:0]     <= rx_data;
          S_BYTE_HI: hi_byte        <= rx_data;
          S_BYTE_LO: begin
            code_data <= DATA_W'({hi_byte, rx_data});
            code_addr <= addr;
          end
          default: ;
        endcase
      end
      if ((state == S_WRITE) && !last_word) begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 9, code memory address width.
REQ-002 Parameter DATA_W, default 16, code word width; fixed as two bytes.
REQ-003 clk  in  1  rising-edge clock, shared with the datapath.
REQ-004 rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-005 start  in  1  single-cycle request to begin a program load.
REQ-006 abort  in  1  cancel load or run; return to IDLE.
REQ-007 rx_data  in  8  incoming program byte.
REQ-008 rx_valid  in  1  rx_data valid.
REQ-009 rx_ready  out  1  loader accepts a byte this cycle.
REQ-010 code_w_en  out  1  code memory write strobe to the datapath.
REQ-011 code_addr  out  ADDR_W  code memory write address.
REQ-012 code_data  out  DATA_W  code memory write word.
REQ-013 run  out  1  datapath run enable.
REQ-014 busy  out  1  load in progress.
REQ-015 error  out  1  malformed header latched.

Function
REQ-016 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both 1; rx_ready SHALL be 1 only in LEN_HI, LEN_LO, BYTE_HI and BYTE_LO.
REQ-017 The FSM SHALL have the states IDLE, LEN_HI, LEN_LO, BYTE_HI, BYTE_LO, WRITE, RUN and ERR.
REQ-018 In IDLE, RUN or ERR, start without abort SHALL go to LEN_HI next cycle and clear run, error and the address counter.
REQ-019 In any other state, start SHALL be ignored.
REQ-020 LEN_HI: if the accepted byte has bits[7:1] nonzero, go to ERR; otherwise set count[8] = bit[0] and go to LEN_LO.
REQ-021 LEN_LO: set count[7:0] = byte; if count==0, go to ERR, else go to BYTE_HI.
- Valid counts are 1..511.
REQ-022 BYTE_HI: the accepted byte SHALL load code_data[15:8]; then go to BYTE_LO.
REQ-023 BYTE_LO: the accepted byte SHALL load code_data[7:0]; then go to WRITE.
REQ-024 WRITE SHALL last exactly one cycle, with code_w_en=1 and code_addr equal to the address counter.
- If addr == count-1, go to RUN; otherwise increment addr and go to BYTE_HI.
REQ-025 code_w_en SHALL be 1 only in WRITE; code_addr and code_data SHALL hold their values in every other state.
REQ-026 Latency: final byte accepted at edge N -> code_w_en high in cycle N+1 -> run=1 from edge N+2.
REQ-027 run SHALL be 1 only in RUN, and SHALL stay 1 until start or abort.
REQ-028 ERR SHALL hold error=1 and run=0 until start (reload) or abort.
REQ-029 abort SHALL take priority over start and all bytes.
- From any state, next cycle: IDLE, run=0, error=0, code_w_en=0.
- No partial WRITE SHALL be issued.
REQ-030 busy SHALL equal 1 exactly in LEN_HI, LEN_LO, BYTE_HI, BYTE_LO and WRITE.
REQ-031 rx_valid held while rx_ready=0 SHALL NOT be consumed; byte gaps of any length SHALL be tolerated.

Reset
REQ-032 While rst_n=0, state SHALL be IDLE, and all outputs, count, addr and code_data SHALL be 0, independent of clk.
REQ-033 Deassertion of rst_n mid-load SHALL NOT resume the load; a new start is required.

Structure
REQ-034 State encodings, ADDR_W/DATA_W defaults and the LEN header layout SHALL live in the shared constants include.
REQ-035 The design SHALL be a single module with an inline address counter and word assembler; no sub-module.

Verification
REQ-036 Load of 3 words: bytes 00,03,12,34,AB,CD,00,FF -> writes 0x1234@0, 0xABCD@1, 0x00FF@2; run=1 two cycles after the last byte.
REQ-037 Header 02,05 -> error=1, rx_ready=0, no write; a following start plus a valid header -> load succeeds.
REQ-038 Header 00,00 -> ERR; abort -> IDLE with error=0.
REQ-039 abort asserted after BYTE_HI of word 1 of 2 -> no further code_w_en; run stays 0; busy=0 next cycle.
REQ-040 rst_n pulled low during WRITE -> code_w_en drops immediately; all outputs 0; no run after release.
REQ-041 Length 511 with random rx_valid gaps -> 511 writes at addresses 0..510, in order, with no skipped or duplicated address.
